mem_arbiter: RTL and testbench

Single-port memory arbiter between the instruction and data caches and the RAM. The icache issues fetch reads (iREN/iaddr) and stalls on iwait; the dcache issues reads and writes (dREN/dWEN/daddr/dstore) and stalls on dwait. The arbiter grants the one RAM port to one requester at a time, holds the grant until RAM completes, and returns load data and wait status. Data requests win by default; a starvation counter stops fetches from being locked out.

---
 rtl/cpu_types_pkg.sv | 22 ++
 rtl/arb_starve_ctr.sv | 50 +++++
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word type, RAM handshake state and memory-arbiter grant state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;

  // Wide enough for any starvation limit in 1..15.
  localparam int unsigned StarveCntW = 4;

endpackage

// File: rtl/arb_starve_ctr.sv
// Starvation counter for the memory arbiter.
// Counts data completions that happened while a fetch was waiting and raises
// forced_o once the count reaches Limit with a fetch still pending.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   ireq_i         icache read request (iREN)
//   d_done_i       a data access completes this cycle
//   i_done_i       an instruction access completes this cycle
//   forced_o       instruction must be granted next from IDLE
module arb_starve_ctr
  import cpu_types_pkg::*;
#(
  parameter int unsigned Limit = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ireq_i,
  input  logic d_done_i,
  input  logic i_done_i,
  output logic forced_o
);

  localparam logic [StarveCntW-1:0] LimitW = StarveCntW'(Limit);

  logic [StarveCntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_done_i) begin
      cnt_d = '0;
    end else if (d_done_i) begin
      if (!ireq_i) begin
        cnt_d = '0;
      end else if (cnt_q != LimitW) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign forced_o = ireq_i && (cnt_q == LimitW);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between icache fetches and dcache reads/writes.
// Data wins by default; one grant is held until RAM reports ACCESS (or the
// requester drops its request), then the block always returns to IDLE.
// Configuration: define MEMARB_FAIRNESS_EN to add the starvation counter that
// forces an instruction grant after STARVE_LIMIT data grants with iREN pending.
// Ports:
//   CLK, nRST                      clock, asynchronous active-low reset
//   iREN, iaddr / iwait, iload     icache request and response
//   dREN, dWEN, daddr, dstore      dcache request
//   dwait, dload                   dcache response
//   ramREN, ramWEN, ramaddr,
//   ramstore / ramload, ramstate   RAM port
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
);

  arb_state_t state_q, state_d;
  logic       d_req;
  logic       i_done;
  logic       d_done;
  logic       forced;

  assign d_req  = dREN | dWEN;
  // ERROR is not ACCESS, so it simply keeps the grant and retries.
  assign i_done = (state_q == IGNT) && iREN && (ramstate == ACCESS);
  assign d_done = (state_q == DGNT) && d_req && (ramstate == ACCESS);

`ifdef MEMARB_FAIRNESS_EN
  arb_starve_ctr #(
    .Limit(STARVE_LIMIT)
  ) u_starve_ctr (
    .clk_i   (CLK),
    .rst_ni  (nRST),
    .ireq_i  (iREN),
    .d_done_i(d_done),
    .i_done_i(i_done),
    .forced_o(forced)
  );
`else
  assign forced = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (d_req && !forced) begin
          state_d = DGNT;
        end else if (iREN) begin
          state_d = IGNT;
        end
      end
      IGNT: if (!iREN || i_done) state_d = IDLE;
      DGNT: if (!d_req || d_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    unique case (state_q)
      IGNT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        if (i_done) begin
          iwait = 1'b0;
          iload = ramload;
        end
      end
      DGNT: begin
        ramREN   = dREN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (d_done) begin
          dwait = 1'b0;
          dload = ramload;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int unsigned Limit = 4;

  logic      CLK = 1'b0;
  logic      nRST;
  logic      iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore, ramload;
  ramstate_t ramstate;
  logic      iwait, dwait, ramREN, ramWEN;
  word_t     iload, dload, ramaddr, ramstore;

  int n_assert = 0;
  int n_fail   = 0;

  mem_arbiter #(
    .STARVE_LIMIT(Limit)
  ) dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .iREN    (iREN),
    .iaddr   (iaddr),
    .iwait   (iwait),
    .iload   (iload),
    .dREN    (dREN),
    .dWEN    (dWEN),
    .daddr   (daddr),
    .dstore  (dstore),
    .dwait   (dwait),
    .dload   (dload),
    .ramREN  (ramREN),
    .ramWEN  (ramWEN),
    .ramaddr (ramaddr),
    .ramstore(ramstore),
    .ramload (ramload),
    .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: who owns the RAM port (0 none, 1 icache, 2 dcache) and
  // how many data grants have been served while a fetch waited.
  // ---------------------------------------------------------------------------
  int owner = 0;
  int starve = 0;

  always @(negedge CLK) begin
    logic  e_iwait, e_dwait, e_ren, e_wen, idone, ddone, forced;
    word_t e_iload, e_dload, e_addr, e_store;
    if (!nRST) begin
      owner  = 0;
      starve = 0;
    end
    e_iwait = 1'b1; e_dwait = 1'b1; e_ren = 1'b0; e_wen = 1'b0;
    e_iload = '0; e_dload = '0; e_addr = '0; e_store = '0;
    idone = (owner == 1) && iREN && (ramstate == ACCESS);
    ddone = (owner == 2) && (dREN || dWEN) && (ramstate == ACCESS);
    if (owner == 1) begin
      e_ren = 1'b1; e_addr = iaddr;
      if (idone) begin e_iwait = 1'b0; e_iload = ramload; end
    end else if (owner == 2) begin
      e_ren = dREN; e_wen = dWEN; e_addr = daddr; e_store = dstore;
      if (ddone) begin e_dwait = 1'b0; e_dload = ramload; end
    end
    n_assert++;
    if ({iwait, dwait, ramREN, ramWEN, ramaddr, ramstore, iload, dload} !==
        {e_iwait, e_dwait, e_ren, e_wen, e_addr, e_store, e_iload, e_dload}) begin
      n_fail++;
      $display("FAIL model_cmp t=%0t owner=%0d: got iw=%b dw=%b ren=%b wen=%b addr=%h st=%h il=%h dl=%h required iw=%b dw=%b ren=%b wen=%b addr=%h st=%h il=%h dl=%h",
               $time, owner, iwait, dwait, ramREN, ramWEN, ramaddr, ramstore, iload, dload,
               e_iwait, e_dwait, e_ren, e_wen, e_addr, e_store, e_iload, e_dload);
    end
    if (nRST) begin
`ifdef MEMARB_FAIRNESS_EN
      forced = iREN && (starve == Limit);
`else
      forced = 1'b0;
`endif
      case (owner)
        0: owner = ((dREN || dWEN) && !forced) ? 2 : (iREN ? 1 : 0);
        1: if (!iREN || idone) owner = 0;
        default: if (!(dREN || dWEN) || ddone) owner = 0;
      endcase
      if (idone) starve = 0;
      else if (ddone) starve = iREN ? ((starve < Limit) ? starve + 1 : starve) : 0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus: inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    iREN = 0; dREN = 0; dWEN = 0; iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = FREE;
  endtask

  initial begin
    int d_before, i_seen, d_between;
    nRST = 1'b0;
    idle_inputs();

    // Reset
    repeat (3) step();
    #1;
    chk("rst_iwait", 32'(iwait), 32'd1);
    chk("rst_dwait", 32'(dwait), 32'd1);
    chk("rst_ramREN", 32'(ramREN), 32'd0);
    chk("rst_ramWEN", 32'(ramWEN), 32'd0);
    chk("rst_ramaddr", ramaddr, 32'h0);
    step();
    nRST = 1'b1;
    step();

    // Lone fetch, ACCESS on the second granted cycle
    iREN = 1; iaddr = 32'h40;
    step();
    ramstate = BUSY; #1;
    chk("fetch_ramaddr", ramaddr, 32'h40);
    chk("fetch_ramREN", 32'(ramREN), 32'd1);
    chk("fetch_wait_busy", 32'(iwait), 32'd1);
    step();
    ramstate = ACCESS; ramload = 32'h2400_0001; #1;
    chk("fetch_iwait_low", 32'(iwait), 32'd0);
    chk("fetch_iload", iload, 32'h2400_0001);
    step();
    iREN = 0; ramstate = FREE; #1;
    chk("fetch_iwait_back", 32'(iwait), 32'd1);
    chk("fetch_iload_zero", iload, 32'h0);
    step();

    // Simultaneous requests: data first, one IDLE bubble, then the fetch
    iREN = 1; iaddr = 32'h44; dREN = 1; daddr = 32'h80; ramstate = ACCESS; ramload = 32'h1234;
    step(); #1;
    chk("sim_ramaddr_d", ramaddr, 32'h80);
    chk("sim_dwait_low", 32'(dwait), 32'd0);
    chk("sim_iwait_high", 32'(iwait), 32'd1);
    step();
    dREN = 0; #1;
    chk("sim_bubble_ren", 32'(ramREN), 32'd0);
    step(); #1;
    chk("sim_ramaddr_i", ramaddr, 32'h44);
    chk("sim_iwait_low", 32'(iwait), 32'd0);
    step();
    idle_inputs();
    step();

    // Write
    dWEN = 1; daddr = 32'h100; dstore = 32'hDEAD_BEEF; ramstate = BUSY;
    step(); #1;
    chk("wr_ramWEN", 32'(ramWEN), 32'd1);
    chk("wr_ramREN", 32'(ramREN), 32'd0);
    chk("wr_ramstore", ramstore, 32'hDEAD_BEEF);
    chk("wr_dwait_busy", 32'(dwait), 32'd1);
    step();
    ramstate = ACCESS; #1;
    chk("wr_dwait_low", 32'(dwait), 32'd0);
    step();
    idle_inputs();
    step();

    // Starvation: both requests held, RAM always ready
    iREN = 1; dREN = 1; ramstate = ACCESS;
    d_before = 0; i_seen = 0; d_between = 0;
    repeat (30) begin
      step(); #1;
      if (!iwait) i_seen++;
      if (!dwait) begin
        if (i_seen == 0) d_before++;
        else if (i_seen == 1) d_between++;
      end
    end
`ifdef MEMARB_FAIRNESS_EN
    chk("starve_d_before_i", 32'(d_before), 32'(Limit));
    chk("starve_d_between_i", 32'(d_between), 32'(Limit));
`else
    chk("strict_no_fetch", 32'(i_seen), 32'd0);
    chk("strict_d_count", 32'(d_before), 32'd15);
`endif
    step();
    idle_inputs();
    repeat (2) step();

    // Abort a fetch before ACCESS
    iREN = 1; iaddr = 32'h200; ramstate = BUSY;
    step(); #1;
    chk("abort_ren_granted", 32'(ramREN), 32'd1);
    iREN = 0; #1;
    chk("abort_no_pulse", 32'(iwait), 32'd1);
    step(); #1;
    chk("abort_idle", 32'(ramREN), 32'd0);
    chk("abort_idle_addr", ramaddr, 32'h0);

    // Reset in the middle of a data write grant
    dWEN = 1; daddr = 32'h300; dstore = 32'h55; ramstate = BUSY;
    step(); #1;
    chk("rstmid_wen_before", 32'(ramWEN), 32'd1);
    nRST = 1'b0; #1;
    chk("rstmid_wen_async", 32'(ramWEN), 32'd0);
    chk("rstmid_addr", ramaddr, 32'h0);
    chk("rstmid_dwait", 32'(dwait), 32'd1);
    step();
    nRST = 1'b1;
    idle_inputs();
    step();

    // Randomized traffic checked by the model on every cycle
    for (int c = 0; c < 4000; c++) begin
      int r;
      step();
      if (iREN) iREN = ($urandom_range(99) < 85);
      else      iREN = ($urandom_range(99) < 30);
      if ($urandom_range(3) == 0) iaddr = $urandom;
      if (dREN || dWEN) begin
        if ($urandom_range(99) >= 80) begin dREN = 0; dWEN = 0; end
      end else if ($urandom_range(99) < 30) begin
        dWEN = $urandom_range(1);
        dREN = !dWEN;
        daddr = $urandom;
        dstore = $urandom;
      end
      r = $urandom_range(99);
      ramstate = (r < 40) ? ACCESS : (r < 55) ? ERROR : (r < 80) ? BUSY : FREE;
      ramload = $urandom;
      nRST = ($urandom_range(499) != 0);
    end
    step();
    nRST = 1'b1;
    idle_inputs();
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
